// File: rtl/beam_scan_summer.sv
// beam_scan_summer: delay-and-sum back end with a direction-scan controller.
// Eight delayed PCM channels are summed into one beam sample. A scan FSM steps
// delay_select through every steering entry, integrates |beam| per direction
// and leaves delay_select on the direction with the greatest energy.
module beam_scan_summer #(
  parameter int DATA_W         = 19,
  parameter int NUM_DIRS       = 30,
  parameter int SETTLE_SAMPLES = 16,
  parameter int INTEG_SAMPLES  = 1024,
  parameter int SUM_W          = DATA_W + 3,
  parameter int ENERGY_W       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic signed [DATA_W-1:0]   delayed_pcm_data_0,
  input  logic signed [DATA_W-1:0]   delayed_pcm_data_1,
  input  logic signed [DATA_W-1:0]   delayed_pcm_data_2,
  input  logic signed [DATA_W-1:0]   delayed_pcm_data_3,
  input  logic signed [DATA_W-1:0]   delayed_pcm_data_4,
  input  logic signed [DATA_W-1:0]   delayed_pcm_data_5,
  input  logic signed [DATA_W-1:0]   delayed_pcm_data_6,
  input  logic signed [DATA_W-1:0]   delayed_pcm_data_7,
  input  logic                       scan_start,
  input  logic                       scan_abort,
  output logic [4:0]                 delay_select,
  output logic signed [SUM_W-1:0]    beam_pcm,
  output logic                       beam_valid,
  output logic [4:0]                 best_dir,
  output logic [ENERGY_W-1:0]        best_energy,
  output logic                       scan_busy,
  output logic                       scan_done
);

  localparam int SET_CW = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam int INT_CW = (INTEG_SAMPLES > 1) ? $clog2(INTEG_SAMPLES) : 1;
  localparam logic [SET_CW-1:0] SET_LAST = SET_CW'(SETTLE_SAMPLES - 1);
  localparam logic [INT_CW-1:0] INT_LAST = INT_CW'(INTEG_SAMPLES - 1);
  localparam logic [4:0]        DIR_LAST = 5'(NUM_DIRS - 1);
  localparam logic [4:0]        DIR_RST  = 5'd30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_INTEG,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [4:0]                 dir_q, dir_d;
  logic [SET_CW-1:0]          settle_q, settle_d;
  logic [INT_CW-1:0]          integ_q, integ_d;
  logic [ENERGY_W-1:0]        acc_q, acc_d;
  logic [4:0]                 best_dir_q, best_dir_d;
  logic [ENERGY_W-1:0]        best_energy_q, best_energy_d;
  logic [4:0]                 shadow_dir_q, shadow_dir_d;
  logic [ENERGY_W-1:0]        shadow_energy_q, shadow_energy_d;
  logic [4:0]                 steer_q, steer_d;
  logic signed [SUM_W-1:0]    beam_pcm_q, beam_pcm_d;
  logic                       beam_valid_q, beam_valid_d;

  logic signed [DATA_W-1:0]   pcm [8];
  logic [SUM_W-1:0]           abs_val;
  logic                       busy;

  assign pcm[0] = delayed_pcm_data_0;
  assign pcm[1] = delayed_pcm_data_1;
  assign pcm[2] = delayed_pcm_data_2;
  assign pcm[3] = delayed_pcm_data_3;
  assign pcm[4] = delayed_pcm_data_4;
  assign pcm[5] = delayed_pcm_data_5;
  assign pcm[6] = delayed_pcm_data_6;
  assign pcm[7] = delayed_pcm_data_7;

  // Summer: exact sign-extended sum of the eight channels, registered on sample_valid.
  always_comb begin
    beam_pcm_d   = beam_pcm_q;
    beam_valid_d = sample_valid;
    if (sample_valid) begin
      beam_pcm_d = '0;
      for (int unsigned i = 0; i < 8; i++) begin
        beam_pcm_d = beam_pcm_d + {{(SUM_W-DATA_W){pcm[i][DATA_W-1]}}, pcm[i]};
      end
    end
  end

  // Energy term: magnitude as unsigned, so the most negative sum maps to 2^(SUM_W-1).
  always_comb begin
    abs_val = beam_pcm_q[SUM_W-1] ? $unsigned(-beam_pcm_q) : $unsigned(beam_pcm_q);
  end

  assign busy = (state_q == S_SETTLE) || (state_q == S_INTEG) || (state_q == S_COMPARE);

  // Scan FSM next-state and datapath updates.
  // Abort is applied after the state case so it overrides any busy-state update
  // and restores the best result captured when the scan started.
  always_comb begin
    state_d         = state_q;
    dir_d           = dir_q;
    settle_d        = settle_q;
    integ_d         = integ_q;
    acc_d           = acc_q;
    best_dir_d      = best_dir_q;
    best_energy_d   = best_energy_q;
    shadow_dir_d    = shadow_dir_q;
    shadow_energy_d = shadow_energy_q;
    steer_d         = steer_q;

    case (state_q)
      S_IDLE: begin
        if (scan_start && !scan_abort) begin
          state_d         = S_SETTLE;
          dir_d           = '0;
          settle_d        = '0;
          shadow_dir_d    = best_dir_q;
          shadow_energy_d = best_energy_q;
        end
      end
      S_SETTLE: begin
        if (beam_valid_q) begin
          if (settle_q == SET_LAST) begin
            state_d = S_INTEG;
            acc_d   = '0;
            integ_d = '0;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
      end
      S_INTEG: begin
        if (beam_valid_q) begin
          acc_d = acc_q + ENERGY_W'(abs_val);
          if (integ_q == INT_LAST) begin
            state_d = S_COMPARE;
          end else begin
            integ_d = integ_q + 1'b1;
          end
        end
      end
      S_COMPARE: begin
        if ((dir_q == '0) || (acc_q > best_energy_q)) begin
          best_energy_d = acc_q;
          best_dir_d    = dir_q;
        end
        if (dir_q == DIR_LAST) begin
          state_d = S_DONE;
        end else begin
          dir_d    = dir_q + 1'b1;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end
      S_DONE: begin
        steer_d = best_dir_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (busy && scan_abort) begin
      state_d       = S_IDLE;
      best_dir_d    = shadow_dir_q;
      best_energy_d = shadow_energy_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      dir_q           <= '0;
      settle_q        <= '0;
      integ_q         <= '0;
      acc_q           <= '0;
      best_dir_q      <= DIR_RST;
      best_energy_q   <= '0;
      shadow_dir_q    <= DIR_RST;
      shadow_energy_q <= '0;
      steer_q         <= DIR_RST;
      beam_pcm_q      <= '0;
      beam_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      dir_q           <= dir_d;
      settle_q        <= settle_d;
      integ_q         <= integ_d;
      acc_q           <= acc_d;
      best_dir_q      <= best_dir_d;
      best_energy_q   <= best_energy_d;
      shadow_dir_q    <= shadow_dir_d;
      shadow_energy_q <= shadow_energy_d;
      steer_q         <= steer_d;
      beam_pcm_q      <= beam_pcm_d;
      beam_valid_q    <= beam_valid_d;
    end
  end

  assign delay_select = busy ? dir_q : steer_q;
  assign beam_pcm     = beam_pcm_q;
  assign beam_valid   = beam_valid_q;
  assign best_dir     = best_dir_q;
  assign best_energy  = best_energy_q;
  assign scan_busy    = busy;
  assign scan_done    = (state_q == S_DONE);

endmodule
